// File: rtl/ncc_feeder_if.sv
// Bus bundle between the NCC feeder, its byte-wide read port and the
// descriptor/window consumer.
interface ncc_feeder_if;
    logic                    start;
    logic                    mem_rd_en;
    logic [15:0]             mem_addr;
    logic [7:0]              mem_rd_data;
    logic                    desc_data_ready;
    logic [31:0]             desc_data_out;
    logic                    window_data_ready;
    logic [15:0][15:0][7:0]  window_data_out;
    logic                    done_with_window_data;
    logic                    busy;
    logic                    all_done;
    logic [8:0]              win_index;

    modport master (
        input  start, mem_rd_data, done_with_window_data,
        output mem_rd_en, mem_addr, desc_data_ready, desc_data_out,
               window_data_ready, window_data_out, busy, all_done, win_index
    );

    modport slave (
        output start, mem_rd_data, done_with_window_data,
        input  mem_rd_en, mem_addr, desc_data_ready, desc_data_out,
               window_data_ready, window_data_out, busy, all_done, win_index
    );
endinterface

// File: rtl/ncc_feeder.sv
// Streams a 16x16 descriptor as packed 32-bit words, then walks every 16x16
// window of the search region, handing each one to the consumer in turn.
module ncc_feeder #(
    parameter int unsigned IMG_W     = 30,
    parameter int unsigned IMG_H     = 25,
    parameter logic [15:0] DESC_BASE = 16'h0000,
    parameter logic [15:0] IMG_BASE  = 16'h0100
) (
    input  logic          clk,
    input  logic          rst,
    ncc_feeder_if.master  bus
);
    localparam int unsigned NX       = IMG_W - 15;
    localparam int unsigned NW       = NX * (IMG_H - 15);
    localparam logic [8:0]  LAST_WIN = 9'(NW - 1);
    localparam logic [8:0]  LAST_X   = 9'(NX - 1);
    localparam logic [15:0] STRIDE   = 16'(IMG_W);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DESC_RD  = 3'd1,
        WIN_FILL = 3'd2,
        WIN_WAIT = 3'd3,
        FINISH   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [8:0]             x_q, x_d;
    logic [8:0]             y_q, y_d;
    logic [8:0]             win_index_q, win_index_d;
    logic                   rd_vld_q, rd_vld_d;
    logic                   rd_win_q, rd_win_d;
    logic [7:0]             rd_idx_q, rd_idx_d;
    logic [31:0]            desc_word_q, desc_word_d;
    logic                   desc_rdy_q, desc_rdy_d;
    logic [15:0][15:0][7:0] win_q, win_d;
    logic                   win_rdy_q, win_rdy_d;

    logic                   rd_en;
    logic [15:0]            rd_addr;
    logic [15:0]            row, col;

    always_comb begin
        row     = 16'(y_q) + {12'd0, cnt_q[7:4]};
        col     = 16'(x_q) + {12'd0, cnt_q[3:0]};
        rd_en   = (state_q == DESC_RD) || (state_q == WIN_FILL);
        rd_addr = (state_q == DESC_RD) ? DESC_BASE + {8'd0, cnt_q}
                                       : IMG_BASE + row * STRIDE + col;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        x_d         = x_q;
        y_d         = y_q;
        win_index_d = win_index_q;
        desc_word_d = desc_word_q;
        desc_rdy_d  = 1'b0;
        win_d       = win_q;
        win_rdy_d   = win_rdy_q;
        // Read data lags the request by one cycle; tag it with its source.
        rd_vld_d    = rd_en;
        rd_win_d    = (state_q == WIN_FILL);
        rd_idx_d    = cnt_q;

        if (rd_vld_q && !rd_win_q) begin
            desc_word_d = {desc_word_q[23:0], bus.mem_rd_data};
            desc_rdy_d  = (rd_idx_q[1:0] == 2'd3);
        end
        if (rd_vld_q && rd_win_q) begin
            win_d[rd_idx_q[7:4]][rd_idx_q[3:0]] = bus.mem_rd_data;
            if (rd_idx_q == 8'hFF) win_rdy_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d     = DESC_RD;
                    cnt_d       = '0;
                    x_d         = '0;
                    y_d         = '0;
                    win_index_d = '0;
                end
            end
            DESC_RD: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'hFF) state_d = WIN_FILL;
            end
            WIN_FILL: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'hFF) state_d = WIN_WAIT;
            end
            WIN_WAIT: begin
                // Acknowledge only counts once the window is actually presented.
                if (win_rdy_q && bus.done_with_window_data) begin
                    win_rdy_d = 1'b0;
                    if (win_index_q == LAST_WIN) begin
                        state_d = FINISH;
                    end else begin
                        state_d     = WIN_FILL;
                        win_index_d = win_index_q + 9'd1;
                        if (x_q == LAST_X) begin
                            x_d = '0;
                            y_d = y_q + 9'd1;
                        end else begin
                            x_d = x_q + 9'd1;
                        end
                    end
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            win_index_q <= '0;
            rd_vld_q    <= 1'b0;
            rd_win_q    <= 1'b0;
            rd_idx_q    <= '0;
            desc_word_q <= '0;
            desc_rdy_q  <= 1'b0;
            win_q       <= '0;
            win_rdy_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            win_index_q <= win_index_d;
            rd_vld_q    <= rd_vld_d;
            rd_win_q    <= rd_win_d;
            rd_idx_q    <= rd_idx_d;
            desc_word_q <= desc_word_d;
            desc_rdy_q  <= desc_rdy_d;
            win_q       <= win_d;
            win_rdy_q   <= win_rdy_d;
        end
    end

    assign bus.mem_rd_en         = rd_en;
    assign bus.mem_addr          = rd_en ? rd_addr : '0;
    assign bus.desc_data_ready   = desc_rdy_q;
    assign bus.desc_data_out     = desc_word_q;
    assign bus.window_data_ready = win_rdy_q;
    assign bus.window_data_out   = win_q;
    assign bus.busy              = (state_q != IDLE);
    assign bus.all_done          = (state_q == FINISH);
    assign bus.win_index         = win_index_q;
endmodule

// File: tb/tb_ncc_feeder.sv
// Bench for ncc_feeder: directed full run on patterned memory, randomized
// partial run against a reference model, and reset/restart corner cases.
module tb_ncc_feeder;
    localparam int IMG_W = 30;
    localparam int IMG_H = 25;
    localparam logic [15:0] DESC_BASE = 16'h0000;
    localparam logic [15:0] IMG_BASE  = 16'h0100;
    localparam int NX = IMG_W - 15;
    localparam int NW = NX * (IMG_H - 15);

    logic clk = 1'b0;
    logic rst;
    ncc_feeder_if bus();

    ncc_feeder #(.IMG_W(IMG_W), .IMG_H(IMG_H), .DESC_BASE(DESC_BASE), .IMG_BASE(IMG_BASE))
        dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    logic [7:0] mem [0:65535];
    always @(posedge clk) bus.mem_rd_data <= bus.mem_rd_en ? mem[bus.mem_addr] : 8'h00;

    int checks = 0;
    int errors = 0;

    // Reference model: address of the n-th read of a run, pixel of window w, descriptor word k.
    function automatic logic [15:0] exp_addr(input int n);
        int w, p;
        if (n < 256) return 16'(int'(DESC_BASE) + n);
        w = (n - 256) / 256;
        p = (n - 256) % 256;
        return 16'(int'(IMG_BASE) + (w / NX + p / 16) * IMG_W + (w % NX) + (p % 16));
    endfunction

    function automatic logic [7:0] exp_pix(input int w, input int r, input int c);
        return mem[16'(int'(IMG_BASE) + (w / NX + r) * IMG_W + (w % NX) + c)];
    endfunction

    function automatic logic [31:0] exp_word(input int k);
        int b;
        b = int'(DESC_BASE) + 4 * k;
        return {mem[16'(b)], mem[16'(b + 1)], mem[16'(b + 2)], mem[16'(b + 3)]};
    endfunction

    // Monitor: per-run statistics, reset whenever run_id changes.
    int run_id = 0;
    int mon_run = 0;
    int cyc = 0;
    int rd_cnt = 0, first_rd_cyc = 0, last_rd_cyc = 0;
    int addr_bad = 0, lat_bad = 0, rise_cnt = 0, alldone_cnt = 0;
    logic [15:0] first_rd_addr = '0;
    logic [31:0] desc_w[$];
    int desc_c[$];
    logic rdy_prev = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_run != run_id) begin
                mon_run = run_id;
                rd_cnt = 0; addr_bad = 0; lat_bad = 0; rise_cnt = 0; alldone_cnt = 0;
                desc_w.delete(); desc_c.delete();
            end
            if (bus.mem_rd_en === 1'b1) begin
                if (rd_cnt == 0) begin
                    first_rd_cyc  = cyc;
                    first_rd_addr = bus.mem_addr;
                end
                if (bus.mem_addr !== exp_addr(rd_cnt)) addr_bad++;
                last_rd_cyc = cyc;
                rd_cnt++;
            end
            if (bus.desc_data_ready === 1'b1) begin
                desc_w.push_back(bus.desc_data_out);
                desc_c.push_back(cyc);
            end
            if (bus.window_data_ready === 1'b1 && !rdy_prev) begin
                rise_cnt++;
                if (cyc - last_rd_cyc != 2) lat_bad++;
            end
            rdy_prev = bus.window_data_ready;
            if (bus.all_done === 1'b1) alldone_cnt++;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        for (int i = 0; i < 3000; i++) begin
            if (bus.window_data_ready === 1'b1) return;
            tick();
        end
        chk({name, "_timeout"}, 64'd0, 64'd1);
        finish_sim();
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_rd_en"},    64'(bus.mem_rd_en), 64'd0);
        chk({tag, "_addr"},     64'(bus.mem_addr), 64'd0);
        chk({tag, "_desc_rdy"}, 64'(bus.desc_data_ready), 64'd0);
        chk({tag, "_desc_out"}, 64'(bus.desc_data_out), 64'd0);
        chk({tag, "_win_rdy"},  64'(bus.window_data_ready), 64'd0);
        chk({tag, "_win_out_nonzero"}, (bus.window_data_out === '0) ? 64'd0 : 64'd1, 64'd0);
        chk({tag, "_busy"},     64'(bus.busy), 64'd0);
        chk({tag, "_all_done"}, 64'(bus.all_done), 64'd0);
        chk({tag, "_win_index"}, 64'(bus.win_index), 64'd0);
    endtask

    typedef struct {
        string       name;
        bit          is_desc;
        int          idx;
        int          r;
        int          c;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[13];
    logic [15:0][15:0][7:0] cap [0:NW-1];

    initial begin
        int idx_bad, hold_bad, sp_bad, bad, n;
        logic [31:0] act;

        vecs[0]  = '{"desc_w0",     1'b1, 0,   0,  0,  32'h00010203};
        vecs[1]  = '{"desc_w1",     1'b1, 1,   0,  0,  32'h04050607};
        vecs[2]  = '{"desc_w32",    1'b1, 32,  0,  0,  32'h80818283};
        vecs[3]  = '{"desc_w63",    1'b1, 63,  0,  0,  32'hFCFDFEFF};
        vecs[4]  = '{"win0_0_0",    1'b0, 0,   0,  0,  32'd0};
        vecs[5]  = '{"win0_15_15",  1'b0, 0,   15, 15, 32'd120};
        vecs[6]  = '{"win14_0_0",   1'b0, 14,  0,  0,  32'd14};
        vecs[7]  = '{"win14_15_15", 1'b0, 14,  15, 15, 32'd134};
        vecs[8]  = '{"win15_0_0",   1'b0, 15,  0,  0,  32'd7};
        vecs[9]  = '{"win16_0_0",   1'b0, 16,  0,  0,  32'd8};
        vecs[10] = '{"win16_15_15", 1'b0, 16,  15, 15, 32'd128};
        vecs[11] = '{"win149_0_0",  1'b0, 149, 0,  0,  32'd77};
        vecs[12] = '{"win149_15_15",1'b0, 149, 15, 15, 32'd197};

        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        for (int i = 0; i < 256; i++) mem[16'(int'(DESC_BASE) + i)] = 8'(i);
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++)
                mem[16'(int'(IMG_BASE) + r * IMG_W + c)] = 8'((r * 7 + c) % 256);

        rst = 1'b1;
        bus.start = 1'b0;
        bus.done_with_window_data = 1'b0;
        repeat (3) tick();
        check_reset("por");
        rst = 1'b0;
        tick();

        // Directed full run on the patterned memory.
        run_id++;
        pulse_start();
        repeat (50) tick();
        pulse_start();
        idx_bad = 0;
        hold_bad = 0;
        for (int w = 0; w < NW; w++) begin
            wait_ready("dir_ready");
            if (bus.win_index !== 9'(w)) idx_bad++;
            cap[w] = bus.window_data_out;
            if (w == NW - 1) chk("last_win_index", 64'(bus.win_index), 64'd149);
            if (w == 3) pulse_start();
            if (w == 0) begin
                for (int i = 0; i < 50; i++) begin
                    tick();
                    if (bus.window_data_ready !== 1'b1 || bus.window_data_out !== cap[0] ||
                        bus.mem_rd_en !== 1'b0) hold_bad++;
                end
                chk("hold_stable", 64'(hold_bad), 64'd0);
                bus.done_with_window_data = 1'b1;
                tick();
                bus.done_with_window_data = 1'b0;
                chk("ack_ready_drop", 64'(bus.window_data_ready), 64'd0);
                chk("ack_rd_resume", 64'(bus.mem_rd_en), 64'd1);
                chk("ack_rd_addr", 64'(bus.mem_addr), 64'(IMG_BASE + 16'd1));
            end else begin
                tick();
                bus.done_with_window_data = 1'b1;
                tick();
                bus.done_with_window_data = 1'b0;
            end
        end
        for (int i = 0; i < 20 && bus.busy !== 1'b0; i++) tick();
        tick();
        chk("busy_end", 64'(bus.busy), 64'd0);
        chk("all_done_pulses", 64'(alldone_cnt), 64'd1);
        chk("window_count", 64'(rise_cnt), 64'(NW));
        chk("win_index_seq", 64'(idx_bad), 64'd0);
        chk("ready_latency", 64'(lat_bad), 64'd0);
        chk("read_count", 64'(rd_cnt), 64'(256 + NW * 256));
        chk("addr_stream", 64'(addr_bad), 64'd0);
        chk("desc_count", 64'(desc_w.size()), 64'd64);
        sp_bad = 0;
        for (int k = 1; k < desc_c.size(); k++) if (desc_c[k] - desc_c[k-1] != 4) sp_bad++;
        chk("desc_spacing", 64'(sp_bad), 64'd0);
        if (desc_c.size() > 0) chk("desc_first_lat", 64'(desc_c[0] - first_rd_cyc), 64'd5);
        bad = 0;
        for (int w = 0; w < NW; w++)
            for (int r = 0; r < 16; r++)
                for (int c = 0; c < 16; c++)
                    if (cap[w][r][c] !== exp_pix(w, r, c)) bad++;
        chk("dir_windows_model", 64'(bad), 64'd0);
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].is_desc)
                act = (vecs[i].idx < desc_w.size()) ? desc_w[vecs[i].idx] : 'x;
            else
                act = {24'd0, cap[vecs[i].idx][vecs[i].r][vecs[i].c]};
            chk(vecs[i].name, 64'(act), 64'(vecs[i].exp));
        end

        // Randomized partial run against the model, then reset in window 5.
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        run_id++;
        pulse_start();
        for (int w = 0; w < 5; w++) begin
            wait_ready("rnd_ready");
            chk($sformatf("rnd_idx%0d", w), 64'(bus.win_index), 64'(w));
            bad = 0;
            for (int r = 0; r < 16; r++)
                for (int c = 0; c < 16; c++)
                    if (bus.window_data_out[r][c] !== exp_pix(w, r, c)) bad++;
            chk($sformatf("rnd_win%0d", w), 64'(bad), 64'd0);
            if (w == 0) begin
                bad = (desc_w.size() == 64) ? 0 : 1;
                for (int k = 0; k < desc_w.size(); k++) if (desc_w[k] !== exp_word(k)) bad++;
                chk("rnd_desc", 64'(bad), 64'd0);
            end
            repeat ($urandom_range(0, 3)) tick();
            bus.done_with_window_data = 1'b1;
            repeat ($urandom_range(1, 3)) tick();
            bus.done_with_window_data = 1'b0;
        end
        for (int i = 0; i < 400 && rd_cnt < 256 + 5 * 256 + 100; i++) tick();
        chk("rnd_addr_stream", 64'(addr_bad), 64'd0);
        chk("rnd_in_fill", 64'(bus.mem_rd_en), 64'd1);
        rst = 1'b1;
        #1;
        check_reset("mid_fill");
        tick();
        rst = 1'b0;
        repeat (2) tick();
        chk("post_rst_win_out_nonzero", (bus.window_data_out === '0) ? 64'd0 : 64'd1, 64'd0);
        chk("post_rst_busy", 64'(bus.busy), 64'd0);

        run_id++;
        pulse_start();
        n = 0;
        for (int i = 0; i < 20 && desc_w.size() == 0; i++) begin tick(); n++; end
        chk("restart_first_addr", 64'(first_rd_addr), 64'(DESC_BASE));
        chk("restart_desc_w0", (desc_w.size() > 0) ? 64'(desc_w[0]) : 64'hDEAD, 64'(exp_word(0)));
        finish_sim();
    end
endmodule
